// File: rtl/decode_stage_if.sv
// Fetch->decode->execute handshake bundle: the D-side instruction word in and
// the registered E-side operands out, each with its own valid/ready pair.
interface decode_stage_if #(
  parameter int WORD = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      D_icode;
  logic [3:0]      D_ifun;
  logic [3:0]      D_rA;
  logic [3:0]      D_rB;
  logic [WORD-1:0] D_valC;
  logic [WORD-1:0] D_valP;

  logic            out_valid;
  logic            out_ready;
  logic [3:0]      E_icode;
  logic [3:0]      E_ifun;
  logic [WORD-1:0] E_valC;
  logic [WORD-1:0] E_valA;
  logic [WORD-1:0] E_valB;
  logic [3:0]      E_srcA;
  logic [3:0]      E_srcB;
  logic [3:0]      E_dstE;
  logic [3:0]      E_dstM;

  // Environment side: fetch drives D, execute consumes E.
  modport master (
    output in_valid, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, out_ready,
    input  in_ready, out_valid, E_icode, E_ifun, E_valC, E_valA, E_valB,
           E_srcA, E_srcB, E_dstE, E_dstM
  );

  // Decode stage side.
  modport slave (
    input  in_valid, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP, out_ready,
    output in_ready, out_valid, E_icode, E_ifun, E_valC, E_valA, E_valB,
           E_srcA, E_srcB, E_dstE, E_dstM
  );
endinterface

// File: rtl/decode_stage.sv
// Y86 decode stage: register id decode, regfile read addressing, E/M/W
// forwarding, load-use stall and the D->E pipeline register.
module decode_stage #(
  parameter int         WORD  = 32,
  parameter logic [3:0] RNONE = 4'hF,
  parameter logic [3:0] RESP  = 4'h4
) (
  input  logic            clk,
  input  logic            reset,
  decode_stage_if.slave   bus,
  output logic [3:0]      readReg1,
  output logic [3:0]      readReg2,
  input  logic [WORD-1:0] valueRead1,
  input  logic [WORD-1:0] valueRead2,
  input  logic [3:0]      e_dstE,
  input  logic [WORD-1:0] e_valE,
  input  logic [3:0]      e_load_dst,
  input  logic [3:0]      M_dstE,
  input  logic [WORD-1:0] M_valE,
  input  logic [3:0]      m_dstM,
  input  logic [WORD-1:0] m_valM,
  input  logic [3:0]      W_dstE,
  input  logic [WORD-1:0] W_valE,
  input  logic [3:0]      W_dstM,
  input  logic [WORD-1:0] W_valM,
  input  logic            flush
);

  localparam logic [3:0] I_NOP = 4'h1;

  logic [3:0]      src_a;
  logic [3:0]      src_b;
  logic [3:0]      dst_e;
  logic [3:0]      dst_m;
  logic [3:0]      src [2];
  logic [WORD-1:0] reg_val [2];
  logic [WORD-1:0] fwd_a;
  logic [WORD-1:0] fwd_b;
  logic [WORD-1:0] val_a;
  logic            hazard;
  logic            slot_free;
  logic            in_ready;
  logic            accept;

  logic            out_valid_reg;
  logic [3:0]      icode_reg;
  logic [3:0]      ifun_reg;
  logic [WORD-1:0] val_c_reg;
  logic [WORD-1:0] val_a_reg;
  logic [WORD-1:0] val_b_reg;
  logic [3:0]      src_a_reg;
  logic [3:0]      src_b_reg;
  logic [3:0]      dst_e_reg;
  logic [3:0]      dst_m_reg;

  // Register id decode straight from the fetch word.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    case (bus.D_icode)
      4'h2: begin
        src_a = bus.D_rA;
        dst_e = bus.D_rB;
      end
      4'h3: begin
        dst_e = bus.D_rB;
      end
      4'h4: begin
        src_a = bus.D_rA;
        src_b = bus.D_rB;
      end
      4'h5: begin
        src_b = bus.D_rB;
        dst_m = bus.D_rA;
      end
      4'h6: begin
        src_a = bus.D_rA;
        src_b = bus.D_rB;
        dst_e = bus.D_rB;
      end
      4'h8: begin
        src_b = RESP;
        dst_e = RESP;
      end
      4'h9: begin
        src_a = RESP;
        src_b = RESP;
        dst_e = RESP;
      end
      4'hA: begin
        src_a = bus.D_rA;
        src_b = RESP;
        dst_e = RESP;
      end
      4'hB: begin
        src_a = RESP;
        src_b = RESP;
        dst_e = RESP;
        dst_m = bus.D_rA;
      end
      default: begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
      end
    endcase
  end

  assign readReg1   = src_a;
  assign readReg2   = src_b;
  assign src[0]     = src_a;
  assign src[1]     = src_b;
  assign reg_val[0] = valueRead1;
  assign reg_val[1] = valueRead2;

  // One forwarding mux per read port; youngest producer wins.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    logic [WORD-1:0] val;
    always_comb begin
      if (src[gi] == RNONE) begin
        val = '0;
      end else if (src[gi] == e_dstE) begin
        val = e_valE;
      end else if (src[gi] == m_dstM) begin
        val = m_valM;
      end else if (src[gi] == M_dstE) begin
        val = M_valE;
      end else if (src[gi] == W_dstM) begin
        val = W_valM;
      end else if (src[gi] == W_dstE) begin
        val = W_valE;
      end else begin
        val = reg_val[gi];
      end
    end
  end

  assign fwd_a = g_fwd[0].val;
  assign fwd_b = g_fwd[1].val;

  // call and jXX carry the return / fall-through address in valA.
  assign val_a = (bus.D_icode == 4'h7 || bus.D_icode == 4'h8) ? bus.D_valP : fwd_a;

  // A load in execute cannot forward yet; its dstM already excludes RNONE.
  assign hazard    = bus.in_valid && (e_load_dst != RNONE) &&
                     ((e_load_dst == src_a) || (e_load_dst == src_b));
  assign slot_free = !out_valid_reg || bus.out_ready;
  assign in_ready  = !hazard && slot_free;
  assign accept    = bus.in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid_reg <= 1'b0;
      icode_reg     <= I_NOP;
      ifun_reg      <= 4'h0;
      val_c_reg     <= '0;
      val_a_reg     <= '0;
      val_b_reg     <= '0;
      src_a_reg     <= RNONE;
      src_b_reg     <= RNONE;
      dst_e_reg     <= RNONE;
      dst_m_reg     <= RNONE;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      icode_reg     <= bus.D_icode;
      ifun_reg      <= bus.D_ifun;
      val_c_reg     <= bus.D_valC;
      val_a_reg     <= val_a;
      val_b_reg     <= fwd_b;
      src_a_reg     <= src_a;
      src_b_reg     <= src_b;
      dst_e_reg     <= dst_e;
      dst_m_reg     <= dst_m;
    end else if (bus.out_ready || (hazard && slot_free)) begin
      // Slot drains with nothing to replace it: insert a bubble.
      out_valid_reg <= 1'b0;
      icode_reg     <= I_NOP;
      ifun_reg      <= 4'h0;
      val_c_reg     <= '0;
      val_a_reg     <= '0;
      val_b_reg     <= '0;
      src_a_reg     <= RNONE;
      src_b_reg     <= RNONE;
      dst_e_reg     <= RNONE;
      dst_m_reg     <= RNONE;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_reg;
  assign bus.E_icode   = icode_reg;
  assign bus.E_ifun    = ifun_reg;
  assign bus.E_valC    = val_c_reg;
  assign bus.E_valA    = val_a_reg;
  assign bus.E_valB    = val_b_reg;
  assign bus.E_srcA    = src_a_reg;
  assign bus.E_srcB    = src_b_reg;
  assign bus.E_dstE    = dst_e_reg;
  assign bus.E_dstM    = dst_m_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: id decode, forwarding priority, load-use
// stall, back-pressure hold and flush bubbles.
module tb_decode_stage;

  logic        clk;
  logic        reset;
  logic [3:0]  readReg1;
  logic [3:0]  readReg2;
  logic [31:0] valueRead1;
  logic [31:0] valueRead2;
  logic [3:0]  e_dstE;
  logic [31:0] e_valE;
  logic [3:0]  e_load_dst;
  logic [3:0]  M_dstE;
  logic [31:0] M_valE;
  logic [3:0]  m_dstM;
  logic [31:0] m_valM;
  logic [3:0]  W_dstE;
  logic [31:0] W_valE;
  logic [3:0]  W_dstM;
  logic [31:0] W_valM;
  logic        flush;
  logic [31:0] rf [16];
  int          checks;
  int          errors;

  decode_stage_if #(.WORD(32)) bus ();

  decode_stage #(.WORD(32), .RNONE(4'hF), .RESP(4'h4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .readReg1   (readReg1),
    .readReg2   (readReg2),
    .valueRead1 (valueRead1),
    .valueRead2 (valueRead2),
    .e_dstE     (e_dstE),
    .e_valE     (e_valE),
    .e_load_dst (e_load_dst),
    .M_dstE     (M_dstE),
    .M_valE     (M_valE),
    .m_dstM     (m_dstM),
    .m_valM     (m_valM),
    .W_dstE     (W_dstE),
    .W_valE     (W_valE),
    .W_dstM     (W_dstM),
    .W_valM     (W_valM),
    .flush      (flush)
  );

  // Combinational register-file model.
  assign valueRead1 = rf[readReg1];
  assign valueRead2 = rf[readReg2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic v, input logic [3:0] icode, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [31:0] valc, input logic [31:0] valp);
    bus.in_valid = v;
    bus.D_icode  = icode;
    bus.D_ifun   = 4'h0;
    bus.D_rA     = ra;
    bus.D_rB     = rb;
    bus.D_valC   = valc;
    bus.D_valP   = valp;
  endtask

  task automatic clear_fwd();
    e_dstE = 4'hF; e_valE = 32'h0; e_load_dst = 4'hF;
    M_dstE = 4'hF; M_valE = 32'h0; m_dstM = 4'hF; m_valM = 32'h0;
    W_dstE = 4'hF; W_valE = 32'h0; W_dstM = 4'hF; W_valM = 32'h0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 16; i++) rf[i] = 32'h0;
    rf[0] = 32'h55; rf[1] = 32'h5; rf[2] = 32'h7; rf[3] = 32'h33; rf[4] = 32'h100;
    clear_fwd();
    flush = 1'b0;
    bus.out_ready = 1'b1;
    set_d(1'b0, 4'h1, 4'hF, 4'hF, 32'h0, 32'h0);

    // Reset then release with nothing to accept.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("rst_E_icode", {28'b0, bus.E_icode}, 32'h1);
    chk("rst_E_dstE", {28'b0, bus.E_dstE}, 32'hF);
    chk("rst_E_dstM", {28'b0, bus.E_dstM}, 32'hF);
    chk("rst_E_valA", bus.E_valA, 32'h0);

    // irmovl $9,%ecx
    set_d(1'b1, 4'h3, 4'hF, 4'h1, 32'h9, 32'h6);
    #1;
    chk("irmovl_in_ready", {31'b0, bus.in_ready}, 32'h1);
    tick();
    chk("irmovl_out_valid", {31'b0, bus.out_valid}, 32'h1);
    chk("irmovl_E_dstE", {28'b0, bus.E_dstE}, 32'h1);
    chk("irmovl_E_valC", bus.E_valC, 32'h9);

    // addl %ecx,%edx with the irmovl result now in execute
    e_dstE = 4'h1; e_valE = 32'h9;
    set_d(1'b1, 4'h6, 4'h1, 4'h2, 32'h0, 32'h8);
    #1;
    chk("addl_readReg1", {28'b0, readReg1}, 32'h1);
    chk("addl_readReg2", {28'b0, readReg2}, 32'h2);
    tick();
    chk("addl_E_valA_fwd_e", bus.E_valA, 32'h9);
    chk("addl_E_valB_rf", bus.E_valB, 32'h7);
    chk("addl_E_dstE", {28'b0, bus.E_dstE}, 32'h2);

    // Load-use: mrmovl into %eax in execute, D = addl %eax,%ebx
    clear_fwd();
    e_load_dst = 4'h0;
    set_d(1'b1, 4'h6, 4'h0, 4'h3, 32'h0, 32'hA);
    #1;
    chk("lu_in_ready_stall", {31'b0, bus.in_ready}, 32'h0);
    tick();
    chk("lu_bubble_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("lu_bubble_icode", {28'b0, bus.E_icode}, 32'h1);
    e_load_dst = 4'hF; m_dstM = 4'h0; m_valM = 32'hABCD;
    #1;
    chk("lu_in_ready_resume", {31'b0, bus.in_ready}, 32'h1);
    tick();
    chk("lu_E_valA_fwd_m", bus.E_valA, 32'hABCD);
    chk("lu_E_valB_rf", bus.E_valB, 32'h33);
    chk("lu_out_valid", {31'b0, bus.out_valid}, 32'h1);

    // call: valA = valP, valB = %esp
    clear_fwd();
    set_d(1'b1, 4'h8, 4'hF, 4'hF, 32'h200, 32'h120);
    tick();
    chk("call_E_valA", bus.E_valA, 32'h120);
    chk("call_E_valB", bus.E_valB, 32'h100);
    chk("call_E_dstE", {28'b0, bus.E_dstE}, 32'h4);
    chk("call_E_dstM", {28'b0, bus.E_dstM}, 32'hF);

    // Back-pressure: E held, decode not ready
    bus.out_ready = 1'b0;
    set_d(1'b1, 4'h3, 4'hF, 4'h2, 32'h77, 32'h126);
    #1;
    chk("bp_in_ready", {31'b0, bus.in_ready}, 32'h0);
    tick();
    chk("bp_hold_valid", {31'b0, bus.out_valid}, 32'h1);
    chk("bp_hold_icode", {28'b0, bus.E_icode}, 32'h8);
    chk("bp_hold_valA", bus.E_valA, 32'h120);
    flush = 1'b1;
    tick();
    chk("bp_flush_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("bp_flush_icode", {28'b0, bus.E_icode}, 32'h1);
    chk("bp_flush_valA", bus.E_valA, 32'h0);
    flush = 1'b0;
    bus.out_ready = 1'b1;

    // Forwarding priority on srcA=3
    e_dstE = 4'h3; e_valE = 32'h11;
    M_dstE = 4'h3; M_valE = 32'h22;
    W_dstE = 4'h3; W_valE = 32'h44;
    set_d(1'b1, 4'h2, 4'h3, 4'h5, 32'h0, 32'h2);
    tick();
    chk("prio_e_over_MW", bus.E_valA, 32'h11);
    e_dstE = 4'hF;
    tick();
    chk("prio_M_over_W", bus.E_valA, 32'h22);
    set_d(1'b1, 4'h2, 4'hF, 4'h5, 32'h0, 32'h2);
    tick();
    chk("srcA_none_valA", bus.E_valA, 32'h0);
    chk("srcA_none_E_srcA", {28'b0, bus.E_srcA}, 32'hF);

    // popl %eax: %esp sources, dstM = rA
    clear_fwd();
    set_d(1'b1, 4'hB, 4'h0, 4'hF, 32'h0, 32'h2);
    tick();
    chk("popl_E_srcA", {28'b0, bus.E_srcA}, 32'h4);
    chk("popl_E_dstM", {28'b0, bus.E_dstM}, 32'h0);
    chk("popl_E_valB", bus.E_valB, 32'h100);

    // Hazard together with flush: bubble, not a stall hold
    e_load_dst = 4'h4;
    flush = 1'b1;
    tick();
    chk("hz_flush_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("hz_flush_dstM", {28'b0, bus.E_dstM}, 32'hF);
    flush = 1'b0;
    clear_fwd();

    // Drain with no new instruction: bubble
    set_d(1'b1, 4'h3, 4'hF, 4'h6, 32'h5, 32'h6);
    tick();
    chk("drain_pre_valid", {31'b0, bus.out_valid}, 32'h1);
    set_d(1'b0, 4'h3, 4'hF, 4'h6, 32'h5, 32'h6);
    tick();
    chk("drain_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("drain_dstE", {28'b0, bus.E_dstE}, 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
